// File: rtl/data_mem_access_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_access_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - RV32I funct3 codes for loads and stores
//   - FSM state encoding
//   - is_legal(): decides whether a request may be issued to the bus
// ---------------------------------------------------------------------------
package data_mem_access_pkg;

    // funct3 codes (stores reuse the B/H/W encodings)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Unsigned variants exist only for loads. Halves need an even address
    // and words a 4-byte aligned address.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !we;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !we && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_mem_access_mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
// Purely combinational byte-lane logic for the load/store unit.
//   we_i          : 1 = store, 0 = load
//   funct3_i      : RV32I access size / signedness
//   addr_lo_i     : byte offset within the word
//   wdata_i       : unshifted store data (rs2)
//   rdata_i       : word returned by the bus
//   bus_wdata_o   : store data replicated onto the addressed lanes
//   bus_wstrb_o   : byte enables (all zero for loads)
//   load_data_o   : extracted and sign/zero-extended load result
// ---------------------------------------------------------------------------
module mem_align
    import data_mem_access_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Store path: sub-word data is replicated across the word so the
    // addressed lanes carry it regardless of offset; strobes pick the lanes.
    always_comb begin
        bus_wdata_o = 32'h0;
        bus_wstrb_o = 4'b0000;
        if (we_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    bus_wdata_o = {4{wdata_i[7:0]}};
                    bus_wstrb_o = 4'b0001 << addr_lo_i;
                end
                2'b01: begin
                    bus_wdata_o = {2{wdata_i[15:0]}};
                    bus_wstrb_o = 4'b0011 << addr_lo_i;
                end
                default: begin
                    bus_wdata_o = wdata_i;
                    bus_wstrb_o = 4'b1111;
                end
            endcase
        end
    end

    // Load path: select the addressed byte/half, then extend.
    always_comb begin
        byteSel = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            2'd3:    byteSel = rdata_i[31:24];
            default: byteSel = rdata_i[7:0];
        endcase
        halfSel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byteSel[7]}}, byteSel};
            F3_BU:   load_data_o = {24'h0, byteSel};
            F3_H:    load_data_o = {{16{halfSel[15]}}, halfSel};
            F3_HU:   load_data_o = {16'h0, halfSel};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/data_mem_access.sv
// ---------------------------------------------------------------------------
// data_mem_access
// Multi-cycle MEM-stage load/store unit. Takes one load/store from EX,
// issues it on a word-wide valid/grant bus, and returns the aligned,
// extended load word to writeback. Holds the pipeline until the access
// completes or the timeout aborts it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   core_valid/we/funct3/addr/wdata : request from EX
//   core_stall          : hold the pipeline
//   core_done           : one-cycle completion pulse
//   mem2reg_data        : load result, valid with core_done, held otherwise
//   access_err          : misaligned/illegal request (IDLE only, combinational)
//   bus_err             : timeout abort, valid with core_done
//   bus_req/we/addr/wdata/wstrb : bus request side
//   bus_gnt, bus_rvalid, bus_rdata : bus response side
// ---------------------------------------------------------------------------
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_valid,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic        core_done,
    output logic [31:0] mem2reg_data,
    output logic        access_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e       state_q, state_d;
    logic         we_q;
    logic [2:0]   funct3_q;
    logic [31:0]  addr_q;
    logic [31:0]  wdata_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]  result_q, result_d;
    logic         err_q, err_d;

    logic         legal;
    logic         accept;
    logic         timeout;
    logic [31:0]  alignWdata;
    logic [3:0]   alignWstrb;
    logic [31:0]  alignLoad;

    assign legal   = is_legal(core_we, core_funct3, core_addr[1:0]);
    assign accept  = (state_q == ST_IDLE) && core_valid && legal;
    assign timeout = (cnt_q == CNT_LAST);

    mem_align u_align (
        .we_i        (we_q),
        .funct3_i    (funct3_q),
        .addr_lo_i   (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_i     (bus_rdata),
        .bus_wdata_o (alignWdata),
        .bus_wstrb_o (alignWstrb),
        .load_data_o (alignLoad)
    );

    // Next-state logic. A completing handshake wins over the timeout in the
    // same cycle; a load granted on the last allowed cycle is aborted since
    // its data could only arrive after the budget expired.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_gnt && we_q) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    state_d  = ST_DONE;
                    err_d    = 1'b1;
                    result_d = 32'h0;
                end else if (bus_gnt) begin
                    state_d = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_rvalid) begin
                    state_d  = ST_DONE;
                    err_d    = 1'b0;
                    result_d = alignLoad;
                end else if (timeout) begin
                    state_d  = ST_DONE;
                    err_d    = 1'b1;
                    result_d = 32'h0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // The request is captured once on acceptance so the bus sees a stable
    // address/data for the whole REQ phase, independent of EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else if (accept) begin
            we_q     <= core_we;
            funct3_q <= core_funct3;
            addr_q   <= core_addr;
            wdata_q  <= core_wdata;
        end
    end

    // Bus outputs are decoded from state so reset removes the request at once.
    always_comb begin
        core_stall   = accept || (state_q == ST_REQ) || (state_q == ST_WAIT_R);
        core_done    = (state_q == ST_DONE);
        mem2reg_data = result_q;
        access_err   = (state_q == ST_IDLE) && core_valid && !legal;
        bus_err      = (state_q == ST_DONE) && err_q;
        bus_req      = (state_q == ST_REQ);
        bus_we       = 1'b0;
        bus_addr     = 32'h0;
        bus_wdata    = 32'h0;
        bus_wstrb    = 4'b0000;
        if (state_q == ST_REQ) begin
            bus_we    = we_q;
            bus_addr  = {addr_q[31:2], 2'b00};
            bus_wdata = alignWdata;
            bus_wstrb = alignWstrb;
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// ---------------------------------------------------------------------------
// tb_data_mem_access
// Self-checking bench for data_mem_access. Expected completions are queued
// when a request is driven and popped when core_done is observed.
// ---------------------------------------------------------------------------
module tb_data_mem_access;

    localparam int TIMEOUT = 256;

    logic        clk;
    logic        rst_n;
    logic        core_valid;
    logic        core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        core_done;
    logic [31:0] mem2reg_data;
    logic        access_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] lastResult;

    data_mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_valid   (core_valid),
        .core_we      (core_we),
        .core_funct3  (core_funct3),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_stall   (core_stall),
        .core_done    (core_done),
        .mem2reg_data (mem2reg_data),
        .access_err   (access_err),
        .bus_err      (bus_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference load extraction written with shifts and masks.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * int'(off))) & 32'h0000_00FF;
        h = (word >> (16 * int'(off[1]))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b[7]  ? (b | 32'hFFFF_FF00) : b);
            3'b100:  return b;
            3'b001:  return (h[15] ? (h | 32'hFFFF_0000) : h);
            3'b101:  return h;
            default: return word;
        endcase
    endfunction

    // Drives one request and plays the bus: grant after gntDelay REQ cycles,
    // read data the cycle after a load grant (if giveRvalid). Returns what
    // was seen at completion plus a snapshot of the first REQ cycle.
    task automatic do_access(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int gntDelay, input logic [31:0] rdata,
                             input bit giveRvalid,
                             output int lat, output logic [31:0] data,
                             output logic berr, output logic acceptStall,
                             output logic [31:0] firstAddr,
                             output logic [3:0] firstStrb,
                             output logic [31:0] firstWdata,
                             output int reqCycles, output bit reqStable);
        int cyc;
        bit rvPending;
        bit seenDone;
        lat = -1; data = 32'h0; berr = 1'b0;
        firstAddr = 32'h0; firstStrb = 4'h0; firstWdata = 32'h0;
        reqCycles = 0; reqStable = 1'b1;
        rvPending = 1'b0; seenDone = 1'b0;
        @(posedge clk); #1;
        core_valid = 1'b1; core_we = we; core_funct3 = f3;
        core_addr = addr; core_wdata = wdata;
        #1;
        acceptStall = core_stall;
        cyc = 1;
        while (!seenDone && cyc < TIMEOUT + 20) begin
            @(posedge clk); #1;
            cyc++;
            core_valid = 1'b0;
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
            if (rvPending && giveRvalid) begin
                bus_rvalid = 1'b1;
                bus_rdata  = rdata;
            end
            rvPending = 1'b0;
            if (bus_req) begin
                if (reqCycles == 0) begin
                    firstAddr  = bus_addr;
                    firstStrb  = bus_wstrb;
                    firstWdata = bus_wdata;
                end else if (bus_addr !== firstAddr || bus_wstrb !== firstStrb ||
                             bus_wdata !== firstWdata || bus_we !== we) begin
                    reqStable = 1'b0;
                end
                if (reqCycles >= gntDelay) begin
                    bus_gnt = 1'b1;
                    if (!we) rvPending = 1'b1;
                end
                reqCycles++;
            end
            #1;
            if (core_done) begin
                seenDone = 1'b1;
                lat  = cyc;
                data = mem2reg_data;
                berr = bus_err;
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++;
        if ({core_stall, core_done, access_err, bus_err} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_core_flags: got %b, expected 0000",
                     {core_stall, core_done, access_err, bus_err});
        end
        testsRun++;
        if (mem2reg_data !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mem2reg: got %h, expected 00000000", mem2reg_data);
        end
        testsRun++;
        if ({bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata} !== 70'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_bus: req=%b we=%b strb=%b addr=%h wdata=%h, expected all 0",
                     bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata);
        end
        lastResult = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        int lat; logic [31:0] d; logic e; logic st; logic [31:0] fa; logic [3:0] fs;
        logic [31:0] fw; int rc; bit stb; exp_t x;
        expQ.push_back('{32'hDEAD_BEEF, 1'b0});
        lastResult = 32'hDEAD_BEEF;
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1'b1,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (d !== x.data || e !== x.err) begin
            testsFailed++;
            $display("[TB] FAIL lw_data: got %h err=%b, expected %h err=%b", d, e, x.data, x.err);
        end
        testsRun++;
        if (lat !== 4) begin
            testsFailed++;
            $display("[TB] FAIL lw_latency: got %0d, expected 4", lat);
        end
        testsRun++;
        if (st !== 1'b1 || fa !== 32'h100 || fs !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL lw_issue: stall=%b addr=%h strb=%b, expected 1 00000100 0000", st, fa, fs);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3Tab[4]  = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] adTab[4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] expTab[4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF};
        int lat; logic [31:0] d; logic e; logic st; logic [31:0] fa; logic [3:0] fs;
        logic [31:0] fw; int rc; bit stb; exp_t x;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back('{expTab[i], 1'b0});
            lastResult = expTab[i];
            do_access(1'b0, f3Tab[i], adTab[i], 32'h0, 0, 32'h80FF_0000, 1'b1,
                      lat, d, e, st, fa, fs, fw, rc, stb);
            x = expQ.pop_front();
            testsRun++;
            if (d !== x.data || e !== x.err || lat !== 4) begin
                testsFailed++;
                $display("[TB] FAIL load_extend_%0d: got %h err=%b lat=%0d, expected %h err=%b lat=4",
                         i, d, e, lat, x.data, x.err);
            end
        end
    endtask

    task automatic test_sh_stall();
        int lat; logic [31:0] d; logic e; logic st; logic [31:0] fa; logic [3:0] fs;
        logic [31:0] fw; int rc; bit stb; exp_t x;
        expQ.push_back('{lastResult, 1'b0});
        do_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 32'h0, 1'b0,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (fa !== 32'h200 || fs !== 4'b1100 || fw !== 32'hABCD_ABCD) begin
            testsFailed++;
            $display("[TB] FAIL sh_lanes: addr=%h strb=%b wdata=%h, expected 00000200 1100 abcdabcd", fa, fs, fw);
        end
        testsRun++;
        if (rc !== 4 || stb !== 1'b1 || lat !== 6) begin
            testsFailed++;
            $display("[TB] FAIL sh_hold: reqCycles=%0d stable=%b lat=%0d, expected 4 1 6", rc, stb, lat);
        end
        testsRun++;
        if (d !== x.data || e !== x.err) begin
            testsFailed++;
            $display("[TB] FAIL sh_result_held: got %h err=%b, expected %h err=%b", d, e, x.data, x.err);
        end
    endtask

    task automatic test_sb_sw();
        int lat; logic [31:0] d; logic e; logic st; logic [31:0] fa; logic [3:0] fs;
        logic [31:0] fw; int rc; bit stb; exp_t x;
        expQ.push_back('{lastResult, 1'b0});
        do_access(1'b1, 3'b000, 32'h101, 32'h0000_00A5, 0, 32'h0, 1'b0,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (fa !== 32'h100 || fs !== 4'b0010 || fw !== 32'hA5A5_A5A5 || lat !== 3 || d !== x.data) begin
            testsFailed++;
            $display("[TB] FAIL sb_store: addr=%h strb=%b wdata=%h lat=%0d res=%h, expected 00000100 0010 a5a5a5a5 3 %h",
                     fa, fs, fw, lat, d, x.data);
        end
        expQ.push_back('{lastResult, 1'b0});
        do_access(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'h0, 1'b0,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (fa !== 32'h300 || fs !== 4'b1111 || fw !== 32'hCAFE_F00D || lat !== 4 || e !== x.err) begin
            testsFailed++;
            $display("[TB] FAIL sw_store: addr=%h strb=%b wdata=%h lat=%0d err=%b, expected 00000300 1111 cafef00d 4 0",
                     fa, fs, fw, lat, e);
        end
    endtask

    task automatic test_misaligned();
        logic        weTab[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3Tab[6] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b011, 3'b100};
        logic [31:0] adTab[6] = '{32'h101, 32'h103, 32'h102, 32'h201, 32'h100, 32'h100};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            core_valid = 1'b1; core_we = weTab[i]; core_funct3 = f3Tab[i];
            core_addr = adTab[i]; core_wdata = 32'h1111_2222;
            #1;
            testsRun++;
            if ({access_err, core_stall, bus_req} !== 3'b100) begin
                testsFailed++;
                $display("[TB] FAIL access_err_%0d: err/stall/req=%b, expected 100",
                         i, {access_err, core_stall, bus_req});
            end
            @(posedge clk); #1;
            core_valid = 1'b0;
            #1;
            testsRun++;
            if ({access_err, core_stall, bus_req, core_done} !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL access_err_idle_%0d: err/stall/req/done=%b, expected 0000",
                         i, {access_err, core_stall, bus_req, core_done});
            end
        end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] d; logic e; logic st; logic [31:0] fa; logic [3:0] fs;
        logic [31:0] fw; int rc; bit stb; exp_t x;
        // Granted load whose data never arrives.
        expQ.push_back('{32'h0, 1'b1});
        lastResult = 32'h0;
        do_access(1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h0, 1'b0,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (d !== x.data || e !== x.err || lat !== TIMEOUT + 2) begin
            testsFailed++;
            $display("[TB] FAIL timeout_rvalid: got %h err=%b lat=%0d, expected %h err=%b lat=%0d",
                     d, e, lat, x.data, x.err, TIMEOUT + 2);
        end
        // Refresh the result register, then a request that is never granted.
        expQ.push_back('{32'h0000_0077, 1'b0});
        do_access(1'b0, 3'b100, 32'h401, 32'h0, 0, 32'h1234_7756, 1'b1,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (d !== x.data || e !== x.err) begin
            testsFailed++;
            $display("[TB] FAIL timeout_recover: got %h err=%b, expected %h err=%b", d, e, x.data, x.err);
        end
        expQ.push_back('{32'h0, 1'b1});
        do_access(1'b1, 3'b010, 32'h404, 32'h5555_5555, 100000, 32'h0, 1'b0,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (d !== x.data || e !== x.err || lat !== TIMEOUT + 2 || rc !== TIMEOUT) begin
            testsFailed++;
            $display("[TB] FAIL timeout_no_gnt: got %h err=%b lat=%0d req=%0d, expected %h err=%b lat=%0d req=%0d",
                     d, e, lat, rc, x.data, x.err, TIMEOUT + 2, TIMEOUT);
        end
        lastResult = 32'h0;
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] d; logic e; logic st; logic [31:0] fa; logic [3:0] fs;
        logic [31:0] fw; int rc; bit stb; exp_t x;
        @(posedge clk); #1;
        core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010;
        core_addr = 32'h500; core_wdata = 32'h0;
        @(posedge clk); #1;
        core_valid = 1'b0;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        #1;
        testsRun++;
        if ({core_stall, bus_req} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL wait_r_before_reset: stall/req=%b, expected 10", {core_stall, bus_req});
        end
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({core_stall, bus_req, core_done} !== 3'b000 || mem2reg_data !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_wait: stall/req/done=%b data=%h, expected 000 00000000",
                     {core_stall, bus_req, core_done}, mem2reg_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back('{32'h55AA_33CC, 1'b0});
        lastResult = 32'h55AA_33CC;
        do_access(1'b0, 3'b010, 32'h504, 32'h0, 0, 32'h55AA_33CC, 1'b1,
                  lat, d, e, st, fa, fs, fw, rc, stb);
        x = expQ.pop_front();
        testsRun++;
        if (d !== x.data || e !== x.err || lat !== 4) begin
            testsFailed++;
            $display("[TB] FAIL lw_after_reset: got %h err=%b lat=%0d, expected %h err=%b lat=4",
                     d, e, lat, x.data, x.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3Tab[5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        int lat; logic [31:0] d; logic e; logic st; logic [31:0] fa; logic [3:0] fs;
        logic [31:0] fw; int rc; bit stb; exp_t x;
        logic [2:0] f3; logic [1:0] off; logic [31:0] word; logic [31:0] addr;
        for (int i = 0; i < 8; i++) begin
            f3   = f3Tab[$urandom_range(0, 4)];
            word = $urandom();
            off  = 2'($urandom_range(0, 3));
            if (f3 == 3'b010) off = 2'b00;
            else if (f3[0]) off[0] = 1'b0;
            addr = {20'h0, 10'($urandom_range(0, 1023)), off};
            expQ.push_back('{modelLoad(f3, off, word), 1'b0});
            lastResult = modelLoad(f3, off, word);
            do_access(1'b0, f3, addr, 32'h0, i % 3, word, 1'b1,
                      lat, d, e, st, fa, fs, fw, rc, stb);
            x = expQ.pop_front();
            testsRun++;
            if (d !== x.data || e !== x.err || fa !== {addr[31:2], 2'b00} || lat !== 4 + (i % 3)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_%0d: f3=%b addr=%h got %h err=%b baddr=%h lat=%0d, expected %h err=%b lat=%0d",
                         i, f3, addr, d, e, fa, lat, x.data, x.err, 4 + (i % 3));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        core_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
        core_addr = 32'h0; core_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        lastResult = 32'h0;
        test_reset();
        test_lw();
        test_load_extend();
        test_sh_stall();
        test_sb_sw();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
